// File: rtl/vend_pkg.sv
// vend_pkg: state encoding, coin codes and the coin value helper shared by vend_ctrl.
package vend_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_DISPENSE = 3'd2;
  localparam logic [2:0] S_CHANGE   = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_COLLECT  = S_COLLECT,
    ST_DISPENSE = S_DISPENSE,
    ST_CHANGE   = S_CHANGE,
    ST_FAULT    = S_FAULT
  } vend_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;

  // 2'b11 is a glitch from the acceptor and counts as no coin.
  function automatic logic [1:0] coin_units(input logic [1:0] coin);
    case (coin)
      COIN_NONE: return 2'd0;
      COIN_50:   return 2'd1;
      COIN_100:  return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timer.sv
// vend_timer: dispense timeout down-counter; start loads TIMEOUT, expired flags
// terminal count while running, clear stops it.
module vend_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (start) begin
      cnt_d = TW'(TIMEOUT);
      run_d = 1'b1;
    end else if (run_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expired = run_q && (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin credit accumulation and dispenser req/ack sequencing.
// Change return and cancel exist only when VEND_CHANGE_RETURN_EN is defined.
//
// state    | meaning
// IDLE     | no credit, waiting for the first coin
// COLLECT  | credit below price, accepting coins
// DISPENSE | disp_req high, waiting for disp_ack or timeout
// CHANGE   | paying back credit one 50 c pulse per cycle
// FAULT    | dispenser never acked; credit frozen
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 6,
  parameter int TIMEOUT    = 15
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [1:0]                           coin,
  input  logic                                 cancel,
  input  logic                                 disp_ack,
  output logic                                 disp_req,
  output logic                                 change_50,
  output logic                                 coin_rej,
  output logic [$clog2(MAX_CREDIT+1)-1:0]      credit,
  output logic                                 busy,
  output logic                                 fault
);

  localparam int CW = $clog2(MAX_CREDIT + 1);

  vend_state_t   state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW:0]   sum;
  logic          coin_vld;
  logic          coin_rej_q, coin_rej_d;
  logic          disp_req_q, disp_req_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;
  logic          tmr_start, tmr_clear, tmr_expired;
`ifdef VEND_CHANGE_RETURN_EN
  logic          change_q, change_d;
`else
  logic          unused_cancel;
  assign unused_cancel = cancel;
`endif

  assign coin_vld = (coin_units(coin) != 2'd0);
  assign sum      = {1'b0, credit_q} + (CW+1)'(coin_units(coin));

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    coin_rej_d = 1'b0;
`ifdef VEND_CHANGE_RETURN_EN
    change_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
`ifdef VEND_CHANGE_RETURN_EN
        if (cancel) begin
          coin_rej_d = coin_vld;
          if (credit_q != '0) state_d = ST_CHANGE;
          else                state_d = ST_IDLE;
        end else
`endif
        begin
          if (coin_vld) begin
            if (sum > (CW+1)'(MAX_CREDIT)) coin_rej_d = 1'b1;
            else                           credit_d   = sum[CW-1:0];
          end
          // Leftover credit after a dispense can already cover the price.
          if (credit_d >= CW'(PRICE))  state_d = ST_DISPENSE;
          else if (credit_d != '0)     state_d = ST_COLLECT;
          else                         state_d = ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        coin_rej_d = coin_vld;
        if (disp_ack) begin
          credit_d = credit_q - CW'(PRICE);
          if (credit_d == '0) state_d = ST_IDLE;
`ifdef VEND_CHANGE_RETURN_EN
          else                state_d = ST_CHANGE;
`else
          else                state_d = ST_COLLECT;
`endif
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
        end
      end
`ifdef VEND_CHANGE_RETURN_EN
      ST_CHANGE: begin
        coin_rej_d = coin_vld;
        if (credit_q != '0) begin
          change_d = 1'b1;
          credit_d = credit_q - CW'(1);
        end
        if (credit_q <= CW'(1)) state_d = ST_IDLE;
      end
`endif
      ST_FAULT: begin
        coin_rej_d = coin_vld;
`ifdef VEND_CHANGE_RETURN_EN
        if (cancel) state_d = ST_CHANGE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    disp_req_d = (state_d == ST_DISPENSE);
    fault_d    = (state_d == ST_FAULT);
    busy_d     = (state_d != ST_IDLE);
  end

  assign tmr_start = (state_d == ST_DISPENSE) && (state_q != ST_DISPENSE);
  assign tmr_clear = (state_d != ST_DISPENSE);

  vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      coin_rej_q <= 1'b0;
      disp_req_q <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      coin_rej_q <= coin_rej_d;
      disp_req_q <= disp_req_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

`ifdef VEND_CHANGE_RETURN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) change_q <= 1'b0;
    else     change_q <= change_d;
  end
  assign change_50 = change_q;
`else
  assign change_50 = 1'b0;
`endif

  assign disp_req = disp_req_q;
  assign coin_rej = coin_rej_q;
  assign credit   = credit_q;
  assign busy     = busy_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed checks of vend_ctrl in three parameterisations sharing one stimulus.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cancel;
  logic       disp_ack;
  logic [1:0] coin;

  logic       a_req, a_chg, a_rej, a_busy, a_flt;
  logic [2:0] a_cr;
  logic       r_req, r_chg, r_rej, r_busy, r_flt;
  logic [1:0] r_cr;
  logic       p_req, p_chg, p_rej, p_busy, p_flt;
  logic [1:0] p_cr;

  int checks   = 0;
  int failures = 0;
  logic [7:0] e8;
  logic [6:0] e7;

  // Observation order: {disp_req, change_50, coin_rej, busy, fault, credit}
  wire [7:0] a_obs = {a_req, a_chg, a_rej, a_busy, a_flt, a_cr};
  wire [6:0] r_obs = {r_req, r_chg, r_rej, r_busy, r_flt, r_cr};
  wire [6:0] p_obs = {p_req, p_chg, p_rej, p_busy, p_flt, p_cr};

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .disp_ack(disp_ack),
    .disp_req(a_req), .change_50(a_chg), .coin_rej(a_rej), .credit(a_cr),
    .busy(a_busy), .fault(a_flt)
  );

  vend_ctrl #(.PRICE(3), .MAX_CREDIT(3), .TIMEOUT(15)) dut_r (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .disp_ack(disp_ack),
    .disp_req(r_req), .change_50(r_chg), .coin_rej(r_rej), .credit(r_cr),
    .busy(r_busy), .fault(r_flt)
  );

  vend_ctrl #(.PRICE(1), .MAX_CREDIT(3), .TIMEOUT(3)) dut_p (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .disp_ack(disp_ack),
    .disp_req(p_req), .change_50(p_chg), .coin_rej(p_rej), .credit(p_cr),
    .busy(p_busy), .fault(p_flt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    coin = 2'b00; cancel = 1'b0; disp_ack = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_obs !== 8'd0) begin failures++; $display("FAIL reset_a got=%b exp=%b", a_obs, 8'd0); end
    checks++; if (r_obs !== 7'd0) begin failures++; $display("FAIL reset_r got=%b exp=%b", r_obs, 7'd0); end
    checks++; if (p_obs !== 7'd0) begin failures++; $display("FAIL reset_p got=%b exp=%b", p_obs, 7'd0); end
  endtask

  task automatic test_coin_50();
    do_reset();
    coin = 2'b11; step();
    e8 = {5'b00000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL coin11_none got=%b exp=%b", a_obs, e8); end
    coin = 2'b01; step();
    e8 = {5'b00010, 3'd1}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c50_1 got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b00010, 3'd2}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c50_2 got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b10010, 3'd3}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c50_3_disp got=%b exp=%b", a_obs, e8); end
    coin = 2'b00; step();
    checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c50_hold got=%b exp=%b", a_obs, e8); end
    disp_ack = 1'b1; step();
    e8 = {5'b00000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c50_ack got=%b exp=%b", a_obs, e8); end
    disp_ack = 1'b0; step();
    checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c50_idle got=%b exp=%b", a_obs, e8); end
  endtask

  task automatic test_coin_100();
    do_reset();
    coin = 2'b10; step();
    e8 = {5'b00010, 3'd2}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_1 got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b10010, 3'd4}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_disp got=%b exp=%b", a_obs, e8); end
    coin = 2'b01; step();
    e8 = {5'b10110, 3'd4}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_rej_in_disp got=%b exp=%b", a_obs, e8); end
    coin = 2'b00; disp_ack = 1'b1; step();
    e8 = {5'b00010, 3'd1}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_ack got=%b exp=%b", a_obs, e8); end
    disp_ack = 1'b0; step();
`ifdef VEND_CHANGE_RETURN_EN
    e8 = {5'b01000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_change got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b00000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_idle got=%b exp=%b", a_obs, e8); end
`else
    e8 = {5'b00010, 3'd1}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_keep got=%b exp=%b", a_obs, e8); end
    coin = 2'b10; step();
    e8 = {5'b10010, 3'd3}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_redisp got=%b exp=%b", a_obs, e8); end
    coin = 2'b00; disp_ack = 1'b1; step();
    e8 = {5'b00000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL c100_idle got=%b exp=%b", a_obs, e8); end
    disp_ack = 1'b0;
`endif
  endtask

  task automatic test_reject();
    do_reset();
    coin = 2'b10; step();
    e7 = {5'b00010, 2'd2}; checks++;
    if (r_obs !== e7) begin failures++; $display("FAIL rej_pre got=%b exp=%b", r_obs, e7); end
    step();
    e7 = {5'b00110, 2'd2}; checks++;
    if (r_obs !== e7) begin failures++; $display("FAIL rej_pulse got=%b exp=%b", r_obs, e7); end
    coin = 2'b00; step();
    e7 = {5'b00010, 2'd2}; checks++;
    if (r_obs !== e7) begin failures++; $display("FAIL rej_clear got=%b exp=%b", r_obs, e7); end
    coin = 2'b01; step();
    e7 = {5'b10010, 2'd3}; checks++;
    if (r_obs !== e7) begin failures++; $display("FAIL rej_at_max_disp got=%b exp=%b", r_obs, e7); end
    coin = 2'b00;
  endtask

  task automatic test_timeout();
    do_reset();
    coin = 2'b10; step();
    coin = 2'b01; step();
    coin = 2'b00;
    e8 = {5'b10010, 3'd3}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_disp got=%b exp=%b", a_obs, e8); end
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++;
      if (a_obs !== e8) begin failures++; $display("FAIL to_wait_%0d got=%b exp=%b", k, a_obs, e8); end
    end
    step();
    e8 = {5'b00011, 3'd3}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_fault got=%b exp=%b", a_obs, e8); end
    coin = 2'b10; step();
    e8 = {5'b00111, 3'd3}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_fault_rej got=%b exp=%b", a_obs, e8); end
    coin = 2'b00; cancel = 1'b1; step();
    cancel = 1'b0;
`ifdef VEND_CHANGE_RETURN_EN
    e8 = {5'b00010, 3'd3}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_cancel got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b01010, 3'd2}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_chg1 got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b01010, 3'd1}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_chg2 got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b01000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_chg3 got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b00000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL to_idle got=%b exp=%b", a_obs, e8); end
`else
    e8 = {5'b00011, 3'd3};
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_obs !== e8) begin failures++; $display("FAIL to_stuck_%0d got=%b exp=%b", k, a_obs, e8); end
      step();
    end
`endif
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    coin = 2'b01; step();
    coin = 2'b00;
    e7 = {5'b10010, 2'd1};
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if (p_obs !== e7) begin failures++; $display("FAIL tb_wait_%0d got=%b exp=%b", k, p_obs, e7); end
      step();
    end
    e7 = {5'b00011, 2'd1}; checks++;
    if (p_obs !== e7) begin failures++; $display("FAIL tb_fault got=%b exp=%b", p_obs, e7); end
    do_reset();
    coin = 2'b01; step();
    coin = 2'b00; step(); step(); step();
    disp_ack = 1'b1; step();
    disp_ack = 1'b0;
    e7 = {5'b00000, 2'd0}; checks++;
    if (p_obs !== e7) begin failures++; $display("FAIL tb_late_ack got=%b exp=%b", p_obs, e7); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    coin = 2'b10; step();
    coin = 2'b00;
    e7 = {5'b10010, 2'd2}; checks++;
    if (p_obs !== e7) begin failures++; $display("FAIL b2b_disp got=%b exp=%b", p_obs, e7); end
    disp_ack = 1'b1; step();
    disp_ack = 1'b0;
    e7 = {5'b00010, 2'd1}; checks++;
    if (p_obs !== e7) begin failures++; $display("FAIL b2b_ack1 got=%b exp=%b", p_obs, e7); end
    step();
`ifdef VEND_CHANGE_RETURN_EN
    e7 = {5'b01000, 2'd0}; checks++;
    if (p_obs !== e7) begin failures++; $display("FAIL b2b_change got=%b exp=%b", p_obs, e7); end
`else
    e7 = {5'b10010, 2'd1}; checks++;
    if (p_obs !== e7) begin failures++; $display("FAIL b2b_redisp got=%b exp=%b", p_obs, e7); end
    disp_ack = 1'b1; step();
    disp_ack = 1'b0;
    e7 = {5'b00000, 2'd0}; checks++;
    if (p_obs !== e7) begin failures++; $display("FAIL b2b_ack2 got=%b exp=%b", p_obs, e7); end
`endif
  endtask

  task automatic test_cancel();
    do_reset();
    cancel = 1'b1; step();
    cancel = 1'b0;
    e8 = {5'b00000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL cancel_idle got=%b exp=%b", a_obs, e8); end
    coin = 2'b01; step();
    cancel = 1'b1; step();
    coin = 2'b00; cancel = 1'b0;
`ifdef VEND_CHANGE_RETURN_EN
    e8 = {5'b00110, 3'd1}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL cancel_coin got=%b exp=%b", a_obs, e8); end
    step();
    e8 = {5'b01000, 3'd0}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL cancel_refund got=%b exp=%b", a_obs, e8); end
`else
    e8 = {5'b00010, 3'd2}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL cancel_ignored got=%b exp=%b", a_obs, e8); end
    step();
    checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL cancel_hold got=%b exp=%b", a_obs, e8); end
`endif
    do_reset();
    coin = 2'b10; step();
    coin = 2'b01; step();
    coin = 2'b00; cancel = 1'b1; step();
    cancel = 1'b0;
    e8 = {5'b10010, 3'd3}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL cancel_in_disp got=%b exp=%b", a_obs, e8); end
  endtask

  task automatic test_async_reset();
    do_reset();
    coin = 2'b10; step(); step();
    coin = 2'b00;
    e8 = {5'b10010, 3'd4}; checks++;
    if (a_obs !== e8) begin failures++; $display("FAIL arst_pre got=%b exp=%b", a_obs, e8); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_obs !== 8'd0) begin failures++; $display("FAIL arst_immediate got=%b exp=%b", a_obs, 8'd0); end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (a_obs !== 8'd0) begin failures++; $display("FAIL arst_after got=%b exp=%b", a_obs, 8'd0); end
  endtask

  initial begin
    rst = 1'b1; coin = 2'b00; cancel = 1'b0; disp_ack = 1'b0;
    test_reset();
    test_coin_50();
    test_coin_100();
    test_reject();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_cancel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
